// File: rtl/game_pkg.sv
// Shared types and constants for the code-presentation game blocks.
// Holds the player FSM states and the nibble selection helper.
package game_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHOW,
    ST_GAP,
    ST_DONE
  } state_e;

  localparam int NIBBLE_W    = 4;
  localparam int CODE_W      = 16;
  localparam int NUM_NIBBLES = 4;
  localparam int REPLAY_MAX  = 3;

  // Index 0 selects the most-significant nibble.
  function automatic logic [NIBBLE_W-1:0] nib_sel(
    input logic [CODE_W-1:0] code,
    input logic [1:0]        idx
  );
    logic [1:0] sh;
    sh = 2'd3 - idx;
    return code[{sh, 2'b00} +: NIBBLE_W];
  endfunction

endpackage

// File: rtl/dwell_counter.sv
// Dwell timer: counts while enabled, pulses expire on the last cycle
// of the current limit and restarts from zero.
module dwell_counter #(
  parameter int CNT_W = 26
) (
  input  logic             clock,
  input  logic             rst,
  input  logic             clear_i,
  input  logic             enable_i,
  input  logic [CNT_W-1:0] limit_i,
  output logic             expire_o
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign expire_o = enable_i && (cnt_q == limit_i - ONE);

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i || expire_o)
      cnt_d = '0;
    else if (enable_i)
      cnt_d = cnt_q + ONE;
  end

  always_ff @(posedge clock) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/pattern_player.sv
// Presents a 16-bit code nibble by nibble with dwell and gap timing.
// Optional replay of the held code under PATTERN_PLAYER_REPLAY_EN.
module pattern_player
  import game_pkg::*;
#(
  parameter int SHOW_CYCLES = 50000000,
  parameter int GAP_CYCLES  = 12500000,
  parameter int CNT_W       = 26
) (
  input  logic        clock,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] pattern,
  input  logic        log_out,
`ifdef PATTERN_PLAYER_REPLAY_EN
  input  logic        replay,
  output logic [1:0]  replays_left,
`endif
  output logic [3:0]  nibble_out,
  output logic        nibble_valid,
  output logic [1:0]  digit_idx,
  output logic        busy,
  output logic        done
);

  localparam logic [CNT_W-1:0] SHOW_LIM = CNT_W'(SHOW_CYCLES);
  localparam logic [CNT_W-1:0] GAP_LIM  = CNT_W'(GAP_CYCLES);
  localparam bit               HAS_GAP  = GAP_CYCLES > 0;
  localparam logic [1:0]       LAST_IDX = 2'(NUM_NIBBLES - 1);

  state_e           state_q, state_d;
  logic [15:0]      held_q, held_d;
  logic [1:0]       digit_q, digit_d;
  logic [3:0]       nib_q, nib_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             cnt_en, cnt_clr, expire;
  logic [CNT_W-1:0] limit;
  logic [1:0]       nxt_idx;
  logic             replay_go;

  assign cnt_en  = (state_q == ST_SHOW) || (state_q == ST_GAP);
  assign cnt_clr = !cnt_en || log_out;
  assign limit   = (state_q == ST_GAP) ? GAP_LIM : SHOW_LIM;
  assign nxt_idx = digit_q + 2'd1;

  dwell_counter #(
    .CNT_W(CNT_W)
  ) u_dwell (
    .clock   (clock),
    .rst     (rst),
    .clear_i (cnt_clr),
    .enable_i(cnt_en),
    .limit_i (limit),
    .expire_o(expire)
  );

`ifdef PATTERN_PLAYER_REPLAY_EN
  logic [1:0] rl_q, rl_d;

  assign replay_go    = replay && (rl_q != 2'd0);
  assign replays_left = rl_q;

  always_comb begin
    rl_d = rl_q;
    if (state_q == ST_IDLE && state_d == ST_SHOW)
      rl_d = 2'(REPLAY_MAX);
    else if (state_q == ST_DONE && state_d == ST_SHOW)
      rl_d = rl_q - 2'd1;
  end

  always_ff @(posedge clock) begin
    if (rst) rl_q <= '0;
    else     rl_q <= rl_d;
  end
`else
  assign replay_go = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (rst) begin
      state_q <= ST_IDLE;
      held_q  <= '0;
      digit_q <= '0;
      nib_q   <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      held_q  <= held_d;
      digit_q <= digit_d;
      nib_q   <= nib_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // log_out wins over a same-cycle dwell expiry.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:
        if (start && !log_out) state_d = ST_SHOW;
      ST_SHOW:
        if (log_out)                 state_d = ST_IDLE;
        else if (expire) begin
          if (digit_q == LAST_IDX)   state_d = ST_DONE;
          else if (HAS_GAP)          state_d = ST_GAP;
        end
      ST_GAP:
        if (log_out)                 state_d = ST_IDLE;
        else if (expire)             state_d = ST_SHOW;
      ST_DONE:
        if (log_out)                 state_d = ST_IDLE;
        else if (replay_go)          state_d = ST_SHOW;
      default:                       state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    held_d  = held_q;
    digit_d = digit_q;
    nib_d   = nib_q;
    valid_d = valid_q;
    busy_d  = busy_q;
    done_d  = done_q;
    if (state_d == ST_IDLE) begin
      digit_d = '0;
      nib_d   = '0;
      valid_d = 1'b0;
      busy_d  = 1'b0;
      done_d  = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          held_d  = pattern;
          digit_d = '0;
          nib_d   = nib_sel(pattern, 2'd0);
          valid_d = 1'b1;
          busy_d  = 1'b1;
          done_d  = 1'b0;
        end
        ST_SHOW, ST_GAP:
          if (expire) begin
            if (state_d == ST_SHOW) begin
              digit_d = nxt_idx;
              nib_d   = nib_sel(held_q, nxt_idx);
              valid_d = 1'b1;
            end else begin
              nib_d   = '0;
              valid_d = 1'b0;
              busy_d  = (state_d == ST_GAP);
              done_d  = (state_d == ST_DONE);
            end
          end
        ST_DONE:
          if (state_d == ST_SHOW) begin
            digit_d = '0;
            nib_d   = nib_sel(held_q, 2'd0);
            valid_d = 1'b1;
            busy_d  = 1'b1;
            done_d  = 1'b0;
          end
        default: ;
      endcase
    end
  end

  assign nibble_out   = nib_q;
  assign nibble_valid = valid_q;
  assign digit_idx    = digit_q;
  assign busy         = busy_q;
  assign done         = done_q;

endmodule

// File: tb/tb_pattern_player.sv
// Bench for pattern_player: two configurations, trace-level reference.
// Replay checks are built when PATTERN_PLAYER_REPLAY_EN is defined.
module tb_pattern_player;

  typedef struct packed {
    logic [3:0] nib;
    logic       val;
    logic [1:0] idx;
    logic       busy;
    logic       done;
  } obs_t;

  localparam int SA = 3;
  localparam int GA = 2;
  localparam int SB = 2;
  localparam int GB = 0;

  logic        clock = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        log_out = 1'b0;
  logic [15:0] pattern = '0;
  logic [3:0]  na, nb;
  logic        va, vb, ba, bb, da, db;
  logic [1:0]  ia, ib;
`ifdef PATTERN_PLAYER_REPLAY_EN
  logic        replay = 1'b0;
  logic [1:0]  rla, rlb;
`endif

  int compared = 0;
  int mismatched = 0;

  always #5 clock = ~clock;

  pattern_player #(
    .SHOW_CYCLES(SA), .GAP_CYCLES(GA), .CNT_W(4)
  ) dut_a (
    .clock(clock), .rst(rst), .start(start),
    .pattern(pattern), .log_out(log_out),
`ifdef PATTERN_PLAYER_REPLAY_EN
    .replay(replay), .replays_left(rla),
`endif
    .nibble_out(na), .nibble_valid(va),
    .digit_idx(ia), .busy(ba), .done(da)
  );

  pattern_player #(
    .SHOW_CYCLES(SB), .GAP_CYCLES(GB), .CNT_W(4)
  ) dut_b (
    .clock(clock), .rst(rst), .start(start),
    .pattern(pattern), .log_out(log_out),
`ifdef PATTERN_PLAYER_REPLAY_EN
    .replay(replay), .replays_left(rlb),
`endif
    .nibble_out(nb), .nibble_valid(vb),
    .digit_idx(ib), .busy(bb), .done(db)
  );

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    compared++;
    assert (got === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_obs(input string tag, input bit which,
                         input obs_t exp);
    obs_t got;
    got = which ? {nb, vb, ib, bb, db} : {na, va, ia, ba, da};
    chk(tag, 32'(got), 32'(exp));
  endtask

  // Expected per-cycle outputs from the cycle after the accepted start.
  function automatic void build(input logic [15:0] p, input int s,
                                input int g, output obs_t q[$]);
    logic [3:0] n;
    q = {};
    for (int k = 0; k < 4; k++) begin
      n = p[15-4*k -: 4];
      for (int c = 0; c < s; c++)
        q.push_back('{n, 1'b1, 2'(k), 1'b1, 1'b0});
      if (k < 3)
        for (int c = 0; c < g; c++)
          q.push_back('{4'h0, 1'b0, 2'(k), 1'b1, 1'b0});
    end
    q.push_back('{4'h0, 1'b0, 2'd3, 1'b0, 1'b1});
  endfunction

  task automatic play_trace(input string tag, input obs_t ta[$],
                            input obs_t tb[$], input int abort_at,
                            input bit by_rst, output bit aborted);
    int lb;
    lb = tb.size() - 1;
    aborted = 1'b0;
    for (int i = 0; i < ta.size(); i++) begin
      chk_obs({tag, "/a"}, 1'b0, ta[i]);
      chk_obs({tag, "/b"}, 1'b1, tb[(i < lb) ? i : lb]);
      if (i == abort_at) begin
        if (by_rst) rst = 1'b1;
        else        log_out = 1'b1;
        step();
        rst = 1'b0;
        log_out = 1'b0;
        chk_obs({tag, "/abort_a"}, 1'b0, '0);
        chk_obs({tag, "/abort_b"}, 1'b1, '0);
        aborted = 1'b1;
        return;
      end
      step();
    end
  endtask

  task automatic present(input logic [15:0] p, input int abort_at,
                         input bit by_rst, input bit keep,
                         input string tag);
    obs_t ta[$], tb[$];
    bit ab;
    build(p, SA, GA, ta);
    build(p, SB, GB, tb);
    pattern = p;
    start = 1'b1;
    step();
    start = 1'b0;
    pattern = 16'($urandom);
`ifdef PATTERN_PLAYER_REPLAY_EN
    chk({tag, "/rl_load"}, 32'(rla), 32'd3);
`endif
    play_trace(tag, ta, tb, abort_at, by_rst, ab);
    if (ab) return;
    start = 1'b1;
    pattern = 16'($urandom);
    step();
    start = 1'b0;
    chk_obs({tag, "/done_a"}, 1'b0, ta[ta.size()-1]);
    chk_obs({tag, "/done_b"}, 1'b1, tb[tb.size()-1]);
    if (keep) return;
    log_out = 1'b1;
    step();
    log_out = 1'b0;
    chk_obs({tag, "/exit_a"}, 1'b0, '0);
    chk_obs({tag, "/exit_b"}, 1'b1, '0);
  endtask

  initial begin
    step();
    step();
    chk_obs("reset_a", 1'b0, '0);
    chk_obs("reset_b", 1'b1, '0);
    rst = 1'b0;
    step();
    chk_obs("idle_a", 1'b0, '0);

    present(16'hA5C3, -1, 1'b0, 1'b0, "a5c3");
    present(16'h1234, -1, 1'b0, 1'b0, "1234");
    present(16'hA5C3, 6, 1'b0, 1'b0, "abort_show2");
    present(16'hFFFF, -1, 1'b0, 1'b0, "ffff");

    start = 1'b1;
    log_out = 1'b1;
    pattern = 16'h5A5A;
    step();
    chk_obs("start_logout_a", 1'b0, '0);
    chk_obs("start_logout_b", 1'b1, '0);
    start = 1'b0;
    log_out = 1'b0;
    step();
    chk_obs("start_logout2_a", 1'b0, '0);

    present(16'hBEEF, -1, 1'b0, 1'b0, "beef");
    present(16'h6C1D, 3, 1'b1, 1'b0, "rst_gap");

    rst = 1'b1;
    start = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk_obs("rst_hold_a", 1'b0, '0);
      chk_obs("rst_hold_b", 1'b1, '0);
    end
    rst = 1'b0;
    start = 1'b0;
    step();
    chk_obs("post_rst_a", 1'b0, '0);

    for (int r = 0; r < 6; r++)
      present(16'($urandom), int'($urandom_range(0, 24)),
              1'($urandom_range(0, 1)), 1'b0, "rand");

`ifdef PATTERN_PLAYER_REPLAY_EN
    begin
      obs_t ta[$], tb[$];
      logic [15:0] p;
      bit ab;
      p = 16'($urandom);
      build(p, SA, GA, ta);
      build(p, SB, GB, tb);
      present(p, -1, 1'b0, 1'b1, "replay0");
      for (int r = 1; r <= 3; r++) begin
        replay = 1'b1;
        step();
        replay = 1'b0;
        chk("replays_left_a", 32'(rla), 32'(3 - r));
        chk("replays_left_b", 32'(rlb), 32'(3 - r));
        play_trace("replay", ta, tb, -1, 1'b0, ab);
      end
      replay = 1'b1;
      step();
      replay = 1'b0;
      chk_obs("replay4_a", 1'b0, ta[ta.size()-1]);
      chk_obs("replay4_b", 1'b1, tb[tb.size()-1]);
      chk("replays_zero", 32'(rla), 32'd0);
      step();
      chk_obs("replay4_hold", 1'b0, ta[ta.size()-1]);
      log_out = 1'b1;
      step();
      log_out = 1'b0;
      chk_obs("replay_exit", 1'b0, '0);
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
